mac_arbiter: RTL and testbench
==============================

Name: mac_arbiter

Overview:
- Round-robin scheduler that shares one mac_core instance between NUM_REQ requester input buffers.
- Each requester exposes a FIFO head (data plus empty flag). The arbiter grants one requester a burst of up to BURST words.
- Words are presented to the MAC one at a time using the MAC's ipbuf_empty / ren_to_ipbuf handshake. Each MAC result is returned tagged with the originating requester id.
- Sits between the per-requester input buffers and mac_core; the result port feeds the output packet path.

Parameters:
- PACKET_WIDTH, 32, width of every data word and MAC result
- NUM_REQ, 4, number of requesters (power of two, 2..8)
- BURST, 4, maximum words issued per grant before re-arbitration (1..15)
- TIMEOUT, 8, cycles to wait in WAIT for the MAC handshake before abort (2..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous soft clear, active-high
- req_empty  in  NUM_REQ  per-requester FIFO empty flag
- req_data  in  NUM_REQ*PACKET_WIDTH  per-requester FIFO head; requester i occupies bits [i*PACKET_WIDTH +: PACKET_WIDTH]
- req_ren  out  NUM_REQ  one-cycle pop strobe per requester
- mac_ipbuf_empty  out  1  drives mac_core ipbuf_empty
- mac_data_in  out  PACKET_WIDTH  drives mac_core data_in
- mac_ren  in  1  from mac_core ren_to_ipbuf
- mac_valid  in  1  from mac_core packet_out_valid
- mac_data_out  in  PACKET_WIDTH  from mac_core data_out
- mac_rst_work  out  1  drives mac_core rst_work
- res_valid  out  1  result strobe
- res_data  out  PACKET_WIDTH  result word
- res_id  out  $clog2(NUM_REQ)  requester id of the result
- busy  out  1  high when state is not IDLE
- err_timeout  out  1  sticky; set on handshake timeout
- err_spurious  out  1  sticky; set when mac_valid arrives outside WAIT

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, beat=0, timer=0.
  - mac_ipbuf_empty=1; mac_data_in=0.
  - req_ren, mac_rst_work, res_valid, res_data, res_id, err flags all 0.
  - Reset mid-burst drops the in-flight word; no pop is issued.
- The MAC handshake is registered: the MAC samples data_in on a cycle where ipbuf_empty=0, then asserts ren and valid one cycle later. The arbiter therefore holds mac_ipbuf_empty=0 for exactly one cycle per word, preventing duplicate sampling.
- FSM states: IDLE, ISSUE, WAIT, NEXT.
- IDLE:
  - grant = first i with req_empty[i]=0, searching from rr_ptr upward with wrap.
  - If any requester is non-empty: latch gnt, mac_data_in <= req_data[gnt], beat=0, go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): mac_ipbuf_empty=0; timer=0; go to WAIT.
- WAIT:
  - mac_ipbuf_empty=1; timer increments each cycle.
  - On mac_ren=1: pulse req_ren[gnt] for 1 cycle. Next cycle: res_valid=1, res_data=mac_data_out, res_id=gnt. beat++. Go to NEXT.
  - If timer reaches TIMEOUT-1 without mac_ren: pulse mac_rst_work for 1 cycle, set err_timeout, no pop, rr_ptr=gnt+1, go to IDLE.
- NEXT (1 cycle, lets the FIFO empty flag settle after the pop):
  - If beat<BURST and req_empty[gnt]=0: mac_data_in <= req_data[gnt], go to ISSUE.
  - Otherwise rr_ptr = gnt+1 (mod NUM_REQ), go to IDLE.
- Throughput: 3 cycles per word inside a burst, plus 1 IDLE cycle per grant.
- req_ren is never asserted for a requester whose req_empty=1, and never for more than one requester in the same cycle.
- mac_valid is only consumed when it coincides with mac_ren in WAIT. mac_valid in any other state sets err_spurious and is otherwise ignored.
- clr=1 has priority over all transitions:
  - Pulse mac_rst_work.
  - state=IDLE; rr_ptr, err flags, res_valid cleared.
  - No pop is issued.
- A requester's empty flag rising during WAIT does not affect the outstanding word; it is checked only in NEXT.
- The beat counter is $clog2(BURST+1) bits wide and cannot overflow.

Decomposition:
- Shared package mac_pkg: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, NEXT=3) and the default PACKET_WIDTH.
- One natural sub-module: rr_pick. It is a combinational round-robin priority encoder with inputs req_empty and rr_ptr, and outputs gnt and any_req. It is reused later by other shared-resource schedulers.

Test Plan:
- Single word: req 2 holds 0xA5A5_0001, others empty → one req_ren[2] pulse; res_valid once with res_data=0xA5A5_0001, res_id=2; busy low 1 cycle after NEXT.
- Fairness: all 4 requesters hold 10 words, BURST=4 → grant order 0,1,2,3,0,…; exactly 4 results per grant; 3 cycles between consecutive res_valid within a burst.
- Short burst: req 1 holds 2 words, BURST=4 → 2 results tagged id 1, then return to IDLE with rr_ptr=2.
- Timeout: MAC model never asserts ren, TIMEOUT=8 → mac_rst_work pulses 8 cycles after ISSUE; err_timeout=1; no req_ren; next arbitration starts from gnt+1.
- clr mid-WAIT and rst mid-burst → no pop, outputs return to reset values, and the same head word is reissued afterwards.
- Spurious mac_valid while in IDLE → err_spurious=1, no res_valid; flag clears only on clr or rst.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC round-robin arbiter.
//   state_t            - arbiter FSM state encoding
//   DEF_PACKET_WIDTH   - default data / result word width
package mac_pkg;

    localparam int unsigned DEF_PACKET_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req_empty  in   per-requester empty flag (a requester is eligible when 0)
//   rr_ptr     in   index searched first; search wraps upward from here
//   gnt        out  first eligible index at or after rr_ptr
//   any_req    out  high when at least one requester is eligible
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_empty,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] gnt,
    output logic                       any_req
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;

    // NUM_REQ is a power of two, so the index addition wraps by itself.
    always_comb begin
        gnt     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = rr_ptr + IW'(i);
            if (!any_req && !req_empty[idx]) begin
                gnt     = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin scheduler sharing one mac_core between NUM_REQ
// requester FIFOs. Each grant issues up to BURST words, one at a time, over
// the MAC's ipbuf_empty / ren_to_ipbuf handshake; results come back tagged
// with the requester id.
//   clk, rst (async, active-low), clr (sync soft clear)
//   req_empty / req_data / req_ren          - requester FIFO heads and pops
//   mac_ipbuf_empty / mac_data_in / mac_ren  - word handshake to mac_core
//   mac_valid / mac_data_out / mac_rst_work  - MAC result and abort
//   res_valid / res_data / res_id            - tagged result stream
//   busy, err_timeout, err_spurious          - status (error flags sticky)
module mac_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BURST        = 4,
    parameter int unsigned TIMEOUT      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic [NUM_REQ-1:0]              req_empty,
    input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ren,
    output logic                            mac_ipbuf_empty,
    output logic [PACKET_WIDTH-1:0]         mac_data_in,
    input  logic                            mac_ren,
    input  logic                            mac_valid,
    input  logic [PACKET_WIDTH-1:0]         mac_data_out,
    output logic                            mac_rst_work,
    output logic                            res_valid,
    output logic [PACKET_WIDTH-1:0]         res_data,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic                            busy,
    output logic                            err_timeout,
    output logic                            err_spurious
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BURST + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t                  state, state_next;
    logic [IW-1:0]           rr_ptr, gnt, pick_gnt;
    logic                    any_req;
    logic [BW-1:0]           beat;
    logic [TW-1:0]           timer;
    logic                    accept, timeout_hit, more;
    logic [PACKET_WIDTH-1:0] req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*PACKET_WIDTH +: PACKET_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_empty (req_empty),
        .rr_ptr    (rr_ptr),
        .gnt       (pick_gnt),
        .any_req   (any_req)
    );

    assign accept      = (state == WAIT) && mac_ren;
    assign timeout_hit = (state == WAIT) && !mac_ren && (timer == TW'(TIMEOUT - 1));
    // The empty flag is only trusted here, one cycle after the pop.
    assign more        = (beat < BW'(BURST)) && !req_empty[gnt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (any_req) state_next = ISSUE;
                ISSUE: state_next = WAIT;
                WAIT: begin
                    if (accept)           state_next = NEXT;
                    else if (timeout_hit) state_next = IDLE;
                end
                NEXT:  state_next = more ? ISSUE : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ipbuf_empty is low only in ISSUE, so the registered MAC samples each
    // word exactly once. The pop is additionally gated by the live empty
    // flag so an empty FIFO is never read.
    always_comb begin
        req_ren         = '0;
        mac_ipbuf_empty = (state != ISSUE);
        mac_rst_work    = clr || timeout_hit;
        busy            = (state != IDLE);
        if (accept && !clr && !req_empty[gnt]) begin
            req_ren[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            gnt          <= '0;
            beat         <= '0;
            timer        <= '0;
            mac_data_in  <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_id       <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (clr) begin
                rr_ptr       <= '0;
                beat         <= '0;
                timer        <= '0;
                err_timeout  <= 1'b0;
                err_spurious <= 1'b0;
            end else begin
                if (mac_valid && (state != WAIT)) begin
                    err_spurious <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (any_req) begin
                            gnt         <= pick_gnt;
                            mac_data_in <= req_word[pick_gnt];
                            beat        <= '0;
                        end
                    end
                    ISSUE: timer <= '0;
                    WAIT: begin
                        if (accept) begin
                            res_valid <= 1'b1;
                            res_data  <= mac_data_out;
                            res_id    <= gnt;
                            beat      <= beat + BW'(1);
                        end else if (timeout_hit) begin
                            err_timeout <= 1'b1;
                            rr_ptr      <= gnt + IW'(1);
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    NEXT: begin
                        if (more) begin
                            mac_data_in <= req_word[gnt];
                        end else begin
                            rr_ptr <= gnt + IW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed self-checking bench for mac_arbiter with
// behavioural requester FIFOs and a pass-through registered MAC model.
module tb_mac_arbiter;

    localparam int PW = 32;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clr = 1'b0;
    logic [NR-1:0]   req_empty, req_ren;
    logic [NR*PW-1:0] req_data;
    logic            mac_ipbuf_empty, mac_ren, mac_valid, mac_rst_work;
    logic            res_valid, busy, err_timeout, err_spurious;
    logic [PW-1:0]   mac_data_in, mac_data_out, res_data;
    logic [1:0]      res_id;

    logic            mac_en = 1'b1;
    logic            spur = 1'b0;
    logic            mac_take = 1'b0;
    logic [PW-1:0]   take_data = '0;
    logic            mdl_ren = 1'b0;
    logic [PW-1:0]   mdl_data = '0;

    logic [PW-1:0]   fifo_mem [NR][16];
    int              rd [NR];
    int              wr [NR];
    int              pop_cnt [NR];
    int              snap [NR];
    logic [NR-1:0]   pend = '0;
    int              cyc = 0;
    int              res_cnt = 0;
    int              bad_ren = 0;
    int              n_cmp = 0;
    int              n_bad = 0;

    mac_arbiter #(
        .PACKET_WIDTH (PW),
        .NUM_REQ      (NR),
        .BURST        (4),
        .TIMEOUT      (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clr             (clr),
        .req_empty       (req_empty),
        .req_data        (req_data),
        .req_ren         (req_ren),
        .mac_ipbuf_empty (mac_ipbuf_empty),
        .mac_data_in     (mac_data_in),
        .mac_ren         (mac_ren),
        .mac_valid       (mac_valid),
        .mac_data_out    (mac_data_out),
        .mac_rst_work    (mac_rst_work),
        .res_valid       (res_valid),
        .res_data        (res_data),
        .res_id          (res_id),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_spurious    (err_spurious)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // MAC: samples data_in while ipbuf_empty is low, answers one cycle later.
    assign mac_ren      = mdl_ren;
    assign mac_valid    = mdl_ren | spur;
    assign mac_data_out = mdl_data;

    always @(negedge clk) begin
        mac_take  <= mac_en && !mac_ipbuf_empty;
        take_data <= mac_data_in;
    end

    always @(posedge clk) begin
        if (!rst) mdl_ren <= 1'b0;
        else      mdl_ren <= mac_take;
        mdl_data <= take_data;
    end

    // FIFOs and bus monitor.
    always_comb begin
        req_empty = '1;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            req_empty[i]          = (rd[i] == wr[i]);
            req_data[i*PW +: PW]  = fifo_mem[i][rd[i] % 16];
        end
    end

    always @(negedge clk) begin
        int b;
        b = 0;
        if ($countones(req_ren) > 1) b++;
        for (int i = 0; i < NR; i++) if (req_ren[i] && req_empty[i]) b++;
        bad_ren <= bad_ren + b;
        pend    <= req_ren;
        if (res_valid) res_cnt <= res_cnt + 1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (pend[i]) begin
                rd[i]      <= rd[i] + 1;
                pop_cnt[i] <= pop_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [PW-1:0] w);
        fifo_mem[i][wr[i] % 16] = w;
        wr[i] = wr[i] + 1;
    endtask

    task automatic take_snap();
        for (int i = 0; i < NR; i++) snap[i] = pop_cnt[i];
    endtask

    task automatic get_res(input string tag, output logic [PW-1:0] d, output logic [1:0] id, output int t);
        bit ok;
        ok = 1'b0; d = '0; id = '0; t = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1; d = res_data; id = res_id; t = cyc;
            end
        end
        check({tag, "_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic expect_res(input string tag, input logic [PW-1:0] ed, input logic [1:0] eid);
        logic [PW-1:0] d;
        logic [1:0]    id;
        int            t;
        get_res(tag, d, id, t);
        check({tag, "_data"}, 64'(d), 64'(ed));
        check({tag, "_id"}, 64'(id), 64'(eid));
    endtask

    task automatic wait_issue(input string tag, output int t);
        bit ok;
        ok = 1'b0; t = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!mac_ipbuf_empty) begin
                ok = 1'b1; t = cyc;
            end
        end
        check({tag, "_issue"}, 64'(ok), 64'd1);
    endtask

    initial begin
        logic [PW-1:0] d;
        logic [1:0]    id;
        int            t0, t1, tp, ti, tr;
        bit            ok;

        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 16; j++) fifo_mem[i][j] = '0;

        // Reset values
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_ipbuf_empty", 64'(mac_ipbuf_empty), 64'd1);
        check("rst_data_in", 64'(mac_data_in), 64'd0);
        check("rst_req_ren", 64'(req_ren), 64'd0);
        check("rst_rst_work", 64'(mac_rst_work), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_to", 64'(err_timeout), 64'd0);
        check("rst_err_sp", 64'(err_spurious), 64'd0);
        @(negedge clk) rst = 1'b1;

        // Single word from requester 2
        take_snap();
        push(2, 32'hA5A5_0001);
        expect_res("single", 32'hA5A5_0001, 2'd2);
        check("single_busy_next", 64'(busy), 64'd1);
        @(negedge clk);
        check("single_busy_low", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("single_pop2", 64'(pop_cnt[2] - snap[2]), 64'd1);
        check("single_pop_other", 64'(pop_cnt[0] - snap[0] + pop_cnt[1] - snap[1] + pop_cnt[3] - snap[3]), 64'd0);

        // Short burst on requester 1, then rr_ptr must start at 2
        push(1, 32'h1111_0001);
        push(1, 32'h1111_0002);
        get_res("short0", d, id, t0);
        check("short0_data", 64'(d), 64'h1111_0001);
        check("short0_id", 64'(id), 64'd1);
        get_res("short1", d, id, t1);
        check("short1_data", 64'(d), 64'h1111_0002);
        check("short1_id", 64'(id), 64'd1);
        check("short_gap", 64'(t1 - t0), 64'd3);
        @(negedge clk);
        check("short_idle", 64'(busy), 64'd0);
        push(2, 32'h2222_0001);
        push(1, 32'h1111_0003);
        expect_res("rrptr_a", 32'h2222_0001, 2'd2);
        expect_res("rrptr_b", 32'h1111_0003, 2'd1);

        // Fairness: 10 words each, bursts of 4
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        take_snap();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 10; k++) push(i, 32'hF000_0000 | (i << 8) | k);
        tp = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) begin
                for (int b = 0; b < ((r < 2) ? 4 : 2); b++) begin
                    get_res("fair", d, id, t0);
                    check("fair_data", 64'(d), 64'(32'hF000_0000 | (i << 8) | (r * 4 + b)));
                    check("fair_id", 64'(id), 64'(i));
                    if (!(r == 0 && i == 0 && b == 0))
                        check("fair_gap", 64'(t0 - tp), (b == 0) ? 64'd4 : 64'd3);
                    tp = t0;
                end
            end
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NR; i++) check("fair_pops", 64'(pop_cnt[i] - snap[i]), 64'd10);

        // Handshake timeout on requester 3
        take_snap();
        mac_en = 1'b0;
        push(3, 32'h3333_0001);
        wait_issue("to", ti);
        ok = 1'b0; tr = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (mac_rst_work) begin
                ok = 1'b1; tr = cyc;
            end
        end
        check("to_rst_work_seen", 64'(ok), 64'd1);
        check("to_delay", 64'(tr - ti), 64'd8);
        push(0, 32'h0000_0007);
        mac_en = 1'b1;
        @(negedge clk);
        check("to_err", 64'(err_timeout), 64'd1);
        check("to_nopop", 64'(pop_cnt[3] - snap[3]), 64'd0);
        expect_res("to_next", 32'h0000_0007, 2'd0);
        expect_res("to_reissue", 32'h3333_0001, 2'd3);
        check("to_err_sticky", 64'(err_timeout), 64'd1);

        // clr during WAIT
        take_snap();
        mac_en = 1'b0;
        push(1, 32'h4444_0001);
        wait_issue("clr", ti);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_rst_work", 64'(mac_rst_work), 64'd1);
        check("clr_no_ren", 64'(req_ren), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        mac_en = 1'b1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_err_to", 64'(err_timeout), 64'd0);
        check("clr_res_valid", 64'(res_valid), 64'd0);
        check("clr_nopop", 64'(pop_cnt[1] - snap[1]), 64'd0);
        expect_res("clr_reissue", 32'h4444_0001, 2'd1);

        // rst mid-burst drops the in-flight word
        take_snap();
        push(2, 32'h5555_0001);
        push(2, 32'h5555_0002);
        expect_res("rstb0", 32'h5555_0001, 2'd2);
        @(negedge clk);
        check("rstb_issue", 64'(mac_ipbuf_empty), 64'd0);
        rst = 1'b0;
        #1;
        check("rstb_ipbuf", 64'(mac_ipbuf_empty), 64'd1);
        check("rstb_data_in", 64'(mac_data_in), 64'd0);
        check("rstb_busy", 64'(busy), 64'd0);
        check("rstb_res_id", 64'(res_id), 64'd0);
        check("rstb_res_data", 64'(res_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_res("rstb_reissue", 32'h5555_0002, 2'd2);
        repeat (3) @(negedge clk);
        check("rstb_pops", 64'(pop_cnt[2] - snap[2]), 64'd2);

        // Spurious mac_valid while idle
        check("sp_before", 64'(err_spurious), 64'd0);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("sp_set", 64'(err_spurious), 64'd1);
        check("sp_no_res", 64'(res_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("sp_sticky", 64'(err_spurious), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("sp_cleared", 64'(err_spurious), 64'd0);

        repeat (2) @(negedge clk);
        check("total_results", 64'(res_cnt), 64'd50);
        check("bad_ren", 64'(bad_ren), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
